// File: rtl/interboard_link_if.sv
// ---------------------------------------------------------------------------
// interboard_link_if
//   Board-to-board pin bundle of the inter-board link: one request/ack/data
//   set per direction.
//   master : the transceiver's view (drives Request_out, inter_data_out,
//            Ack_out; observes Request_in, inter_data_in, Ack_in)
//   slave  : the peer board's view of the same pins
// Parameters: LINK_W - physical data bus width
// ---------------------------------------------------------------------------
interface interboard_link_if #(
  parameter int LINK_W = 6
);
  logic              Request_out;
  logic [LINK_W-1:0] inter_data_out;
  logic              Ack_out;
  logic              Request_in;
  logic [LINK_W-1:0] inter_data_in;
  logic              Ack_in;

  modport master (
    output Request_out, inter_data_out, Ack_out,
    input  Request_in, inter_data_in, Ack_in
  );

  modport slave (
    input  Request_out, inter_data_out, Ack_out,
    output Request_in, inter_data_in, Ack_in
  );
endinterface

// File: rtl/interboard_link.sv
// ---------------------------------------------------------------------------
// interboard_link
//   Full-duplex inter-board transceiver. Sends one {msg_type, number} message
//   per transfer as BEATS LINK_W-bit beats (LSB beat first) over a 4-phase
//   Request/Ack handshake, and receives the same format from the peer.
//   Includes a TX message FIFO, input synchronisers, a TX abort timeout, an
//   RX partial-message resync and a decoded remote-reset pulse.
// Ports:
//   clk, rst (sync, active-low)
//   tx_en/tx_msg_type/tx_number : message push from the game controller
//   tx_ready  : FIFO not full       tx_idle : FIFO empty and TX idle
//   tx_timeout: pulse on message abort
//   link      : board pins (Request/Ack/data in both directions)
//   rx_en/rx_msg_type/rx_number/rx_rst : received message and its strobes
// ---------------------------------------------------------------------------
module interboard_link #(
  parameter int MSG_W       = 3,
  parameter int NUM_W       = 5,
  parameter int LINK_W      = 6,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 65535,
  parameter int RST_TYPE    = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tx_en,
  input  logic [MSG_W-1:0] tx_msg_type,
  input  logic [NUM_W-1:0] tx_number,
  output logic             tx_ready,
  output logic             tx_idle,
  output logic             tx_timeout,
  interboard_link_if.master link,
  output logic             rx_en,
  output logic [MSG_W-1:0] rx_msg_type,
  output logic [NUM_W-1:0] rx_number,
  output logic             rx_rst
);
  localparam int PAY_W  = MSG_W + NUM_W;
  localparam int BEATS  = (PAY_W + LINK_W - 1) / LINK_W;
  localparam int PAD_W  = BEATS * LINK_W;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int CNT_W  = $clog2(TIMEOUT + 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [BEAT_W-1:0] BEAT_ONE  = BEAT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [PTR_W:0]    PTR_ONE   = (PTR_W+1)'(1);

  // ---------------- input synchronisers ----------------
  logic [SYNC_STAGES-1:0] r_req_sync, r_ack_sync;
  logic w_req_s, w_ack_s;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_req_sync <= '0;
      r_ack_sync <= '0;
    end else begin
      r_req_sync <= {r_req_sync[SYNC_STAGES-2:0], link.Request_in};
      r_ack_sync <= {r_ack_sync[SYNC_STAGES-2:0], link.Ack_in};
    end
  end
  assign w_req_s = r_req_sync[SYNC_STAGES-1];
  assign w_ack_s = r_ack_sync[SYNC_STAGES-1];

  // ---------------- TX message FIFO ----------------
  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PAY_W-1:0] r_fifo_mem [FIFO_DEPTH];
  logic [PTR_W:0]   r_wr_ptr, r_rd_ptr;
  logic             w_full, w_empty, w_push, w_pop;
  logic [PAY_W-1:0] w_fifo_head;
  logic [PAD_W-1:0] w_head_pad;

  typedef enum logic [2:0] {T_IDLE, T_SETUP, T_REQ, T_REL, T_DRAIN} tx_state_t;
  tx_state_t r_tx_state;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                   (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
  // Push is gated by the registered full flag only: a same-cycle pop never
  // frees a slot for a push.
  assign w_push  = tx_en && !w_full;
  assign w_pop   = (r_tx_state == T_IDLE) && !w_empty;
  assign w_fifo_head = r_fifo_mem[r_rd_ptr[PTR_W-1:0]];

  always_comb begin
    w_head_pad = '0;
    w_head_pad[PAY_W-1:0] = w_fifo_head;
  end

  always_ff @(posedge clk) begin
    if (w_push) r_fifo_mem[r_wr_ptr[PTR_W-1:0]] <= {tx_msg_type, tx_number};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  assign tx_ready = !w_full;
  assign tx_idle  = w_empty && (r_tx_state == T_IDLE);

  // ---------------- TX FSM ----------------
  logic [PAD_W-1:0]  r_tx_shift;   // beats still to send, next one in the LSBs
  logic [LINK_W-1:0] r_data_out;
  logic              r_req_out, r_tx_timeout;
  logic [BEAT_W-1:0] r_beat;
  logic [CNT_W-1:0]  r_tx_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_tx_state   <= T_IDLE;
      r_tx_shift   <= '0;
      r_data_out   <= '0;
      r_req_out    <= 1'b0;
      r_beat       <= '0;
      r_tx_cnt     <= '0;
      r_tx_timeout <= 1'b0;
    end else begin
      r_tx_timeout <= 1'b0;
      r_tx_cnt     <= r_tx_cnt + CNT_ONE;   // overridden with 0 on every state change
      case (r_tx_state)
        T_IDLE: begin
          r_tx_cnt <= '0;
          if (!w_empty) begin
            r_data_out <= w_head_pad[LINK_W-1:0];
            r_tx_shift <= w_head_pad >> LINK_W;
            r_beat     <= '0;
            r_tx_state <= T_SETUP;
          end
        end
        T_SETUP: begin
          r_tx_cnt   <= '0;
          r_req_out  <= 1'b1;
          r_tx_state <= T_REQ;
        end
        T_REQ: begin
          if (w_ack_s) begin
            r_tx_cnt   <= '0;
            r_req_out  <= 1'b0;
            r_tx_state <= T_REL;
          end else if (r_tx_cnt == CNT_LAST) begin
            r_tx_cnt     <= '0;
            r_req_out    <= 1'b0;
            r_tx_timeout <= 1'b1;
            r_tx_state   <= T_DRAIN;
          end
        end
        T_REL: begin
          if (!w_ack_s) begin
            r_tx_cnt <= '0;
            if (r_beat == LAST_BEAT) begin
              r_tx_state <= T_IDLE;
            end else begin
              r_beat     <= r_beat + BEAT_ONE;
              r_data_out <= r_tx_shift[LINK_W-1:0];
              r_tx_shift <= r_tx_shift >> LINK_W;
              r_tx_state <= T_SETUP;
            end
          end else if (r_tx_cnt == CNT_LAST) begin
            r_tx_cnt     <= '0;
            r_tx_timeout <= 1'b1;
            r_tx_state   <= T_DRAIN;
          end
        end
        T_DRAIN: begin
          // Wait for the peer to drop its ack before reusing the link.
          r_tx_cnt <= '0;
          if (!w_ack_s) r_tx_state <= T_IDLE;
        end
        default: begin
          r_tx_cnt   <= '0;
          r_req_out  <= 1'b0;
          r_tx_state <= T_IDLE;
        end
      endcase
    end
  end

  assign link.Request_out    = r_req_out;
  assign link.inter_data_out = r_data_out;
  assign tx_timeout          = r_tx_timeout;

  // ---------------- RX FSM ----------------
  typedef enum logic {R_WAIT, R_ACK} rx_state_t;
  rx_state_t         r_rx_state;
  logic [BEAT_W-1:0] r_rbeat;
  logic [CNT_W-1:0]  r_rx_cnt;
  logic              r_ack_out, r_rx_done, r_rx_en, r_rx_rst;
  logic [MSG_W-1:0]  r_rx_type;
  logic [NUM_W-1:0]  r_rx_num;
  logic              w_rx_capture;
  logic [PAY_W-1:0]  w_rx_payload;

  // Data is sampled raw: it has been stable since the sender's setup cycle.
  assign w_rx_capture = (r_rx_state == R_WAIT) && w_req_s;

  // One capture register per beat; the last one keeps only payload bits.
  genvar gi;
  generate
    for (gi = 0; gi < BEATS; gi++) begin : g_rx_slot
      localparam int LO = gi * LINK_W;
      localparam int SW = ((PAY_W - LO) < LINK_W) ? (PAY_W - LO) : LINK_W;
      logic [SW-1:0] r_slot;
      always_ff @(posedge clk) begin
        if (!rst) r_slot <= '0;
        else if (w_rx_capture && (r_rbeat == BEAT_W'(gi)))
          r_slot <= link.inter_data_in[SW-1:0];
      end
      assign w_rx_payload[LO +: SW] = r_slot;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rx_state <= R_WAIT;
      r_rbeat    <= '0;
      r_rx_cnt   <= '0;
      r_ack_out  <= 1'b0;
      r_rx_done  <= 1'b0;
      r_rx_en    <= 1'b0;
      r_rx_rst   <= 1'b0;
      r_rx_type  <= '0;
      r_rx_num   <= '0;
    end else begin
      // Message is published one cycle after the final Ack_out fall.
      r_rx_done <= 1'b0;
      r_rx_en   <= r_rx_done;
      r_rx_rst  <= r_rx_done &&
                   (w_rx_payload[PAY_W-1 -: MSG_W] == MSG_W'(RST_TYPE));
      if (r_rx_done) begin
        r_rx_type <= w_rx_payload[PAY_W-1 -: MSG_W];
        r_rx_num  <= w_rx_payload[NUM_W-1:0];
      end
      case (r_rx_state)
        R_WAIT: begin
          if (w_req_s) begin
            r_rx_cnt   <= '0;
            r_ack_out  <= 1'b1;
            r_rx_state <= R_ACK;
          end else if (r_rbeat != '0) begin
            // Peer went quiet mid-message: drop the partial message.
            if (r_rx_cnt == CNT_LAST) begin
              r_rbeat  <= '0;
              r_rx_cnt <= '0;
            end else begin
              r_rx_cnt <= r_rx_cnt + CNT_ONE;
            end
          end else begin
            r_rx_cnt <= '0;
          end
        end
        R_ACK: begin
          r_rx_cnt <= '0;
          if (!w_req_s) begin
            r_ack_out  <= 1'b0;
            r_rx_state <= R_WAIT;
            if (r_rbeat == LAST_BEAT) begin
              r_rbeat   <= '0;
              r_rx_done <= 1'b1;
            end else begin
              r_rbeat <= r_rbeat + BEAT_ONE;
            end
          end
        end
        default: begin
          r_ack_out  <= 1'b0;
          r_rx_state <= R_WAIT;
        end
      endcase
    end
  end

  assign link.Ack_out = r_ack_out;
  assign rx_en        = r_rx_en;
  assign rx_rst       = r_rx_rst;
  assign rx_msg_type  = r_rx_type;
  assign rx_number    = r_rx_num;

endmodule
